alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Execute→writeback pipeline stage directly downstream of the 32-bit ALU.
- Captures the ALU result (z, zf, sf) with its destination register index through a valid/ready skid buffer.
- Presents register-file write requests and maintains the architectural zero/sign flag register used by later branches.
- Full throughput. No combinational path from out_ready to in_ready.

Parameters:
- N, 32, datapath width; must match the ALU.
- RW, 5, destination register index width.

Ports:
- clk  in  1  Single clock domain; all state updates on the rising edge.
- rst_n  in  1  Reset; synchronous, active-low.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  Stage can accept this cycle.
- in_z  in  N  ALU result.
- in_zf  in  1  ALU zero flag.
- in_sf  in  1  ALU sign flag.
- in_rd  in  RW  Destination register index.
- in_setf  in  1  Entry updates the flag register on retirement.
- out_valid  out  1  Writeback entry valid.
- out_ready  in  1  Register file accepts the entry.
- out_z  out  N  Write data.
- out_rd  out  RW  Write index.
- out_we  out  1  Equals out_valid && (out_rd != 0).
- flag_zf  out  1  Architectural zero flag.
- flag_sf  out  1  Architectural sign flag.
- br_cond  in  2  Branch condition code (optional feature).
- br_taken  out  1  Condition result (optional feature).

Behaviour:
- Reset (rst_n low at a clock edge): out_valid=0, out_z=0, out_rd=0, out_we=0, flag_zf=0, flag_sf=0, br_taken=0, skid empty, in_ready=1.
- Reset mid-operation discards both buffered entries. Flags are cleared, not updated by in-flight entries.
- Accept: in_valid && in_ready at an edge. Retire: out_valid && out_ready at an edge.
- Latency: an entry accepted into an empty stage appears on the outputs the next cycle. One result per cycle is sustained while out_ready=1.
- Storage is two entries, main (drives outputs) and skid. Each entry holds {z, zf, sf, rd, setf}.
- in_ready is registered and equals !skid_valid.
- States (from {main_valid, skid_valid}):
  - EMPTY (0,0): accept → FULL1 with main=input.
  - FULL1 (1,0):
    - Retire and accept → FULL1, main=input.
    - Retire only → EMPTY.
    - Accept only → FULL2, skid=input.
    - Neither → hold.
  - FULL2 (1,1): in_ready=0.
    - Retire → FULL1, main=skid.
    - Else hold.
- Ordering is strictly FIFO. The skid entry never overtakes main.
- out_valid, out_z and out_rd are stable while out_valid && !out_ready.
- Flags update only on retirement of an entry with setf=1: flag_zf/flag_sf take that entry's zf/sf, visible the cycle after the retire edge. Entries with setf=0 leave the flags unchanged.
- rd=0: the entry still flows through the stage and can update flags; out_we=0.
- in_valid while in_ready=0: input is ignored. The upstream stage must hold its data.

Optional Feature:
- Macro: ALU_WB_BRANCH_EN.
- Defined: br_taken is combinational from the architectural flags:
  - br_cond 0 → 1 (always)
  - br_cond 1 → flag_zf (eq)
  - br_cond 2 → !flag_zf (ne)
  - br_cond 3 → flag_sf (lt)
- Not defined: br_cond is ignored and br_taken is tied to 0. Ports remain present.

Decomposition:
- Package alu_wb_pkg:
  - N_DEFAULT=32, RW_DEFAULT=5.
  - typedef wb_entry_t {z, zf, sf, rd, setf}.
  - enum br_cond_t {BR_AL, BR_EQ, BR_NE, BR_LT}.
- Sub-module wb_skid_buf: generic two-entry valid/ready skid buffer over wb_entry_t.
- The top module adds out_we, the flag register and the branch logic.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1 → out_valid=0, flags 0, in_ready=1; no entry captured.
- Streaming, out_ready=1, setf=1, rd=3, inputs (z, zf, sf):
  - (0, 1, 0) → out_z=0, flag_zf=1.
  - (0x11223400, 0, 0) → out_z=0x11223400, flag_zf=0.
  - (0x00000000, 1, 0) → out_z=0x00000000, flag_zf=1.
  - (0xfffffffe, 0, 1) → out_z=0xfffffffe, flag_sf=1.
  - Pass criteria: one output per cycle, latency 1, order preserved.
- Backpressure:
  - Drop out_ready for 3 cycles while offering 2 entries (0xA, 0xB) → in_ready falls after the second accept.
  - out_z holds 0xA.
  - On release: 0xA then 0xB; no loss or duplication.
- rd=0 with z=0x5 → out_valid=1, out_we=0. Flags update iff setf=1.
- setf=0 entry with zf=1 after flag_zf=0 → flag_zf stays 0.
- With ALU_WB_BRANCH_EN defined:
  - Flags zf=1, sf=0: br_cond 1 → 1, 2 → 0, 3 → 0, 0 → 1.
  - Without the macro: br_taken=0 always.

Source files
------------

// File: rtl/alu_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wb_pkg
//  Description : Shared types and constants for the ALU writeback stage:
//                default widths, the buffered entry layout and the branch
//                condition encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_wb_pkg;

    localparam int N_DEFAULT  = 32;
    localparam int RW_DEFAULT = 5;

    // One writeback entry as held in either buffer slot.
    typedef struct packed {
        logic [N_DEFAULT-1:0]  z;
        logic                  zf;
        logic                  sf;
        logic [RW_DEFAULT-1:0] rd;
        logic                  setf;
    } wb_entry_t;

    // Branch condition codes evaluated against the architectural flags.
    typedef enum logic [1:0] {
        BR_AL = 2'd0,
        BR_EQ = 2'd1,
        BR_NE = 2'd2,
        BR_LT = 2'd3
    } br_cond_t;

endpackage : alu_wb_pkg
`default_nettype wire

// File: rtl/wb_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : wb_skid_buf
//  Description : Generic two-entry valid/ready skid buffer. The main slot
//                drives the outputs; the skid slot absorbs one extra entry
//                so in_ready can be a pure register (no out_ready -> in_ready
//                combinational path) while still sustaining one entry per
//                cycle. Strict FIFO ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_skid_buf
    import alu_wb_pkg::*;
#(
    parameter type ENTRY_T = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  ENTRY_T in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output ENTRY_T out_data
);

    // Occupancy encoding {main_valid, skid_valid}.
    localparam logic [1:0] c_st_empty = 2'b00;
    localparam logic [1:0] c_st_full1 = 2'b10;
    localparam logic [1:0] c_st_full2 = 2'b11;

    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    ENTRY_T main_q, main_d;
    ENTRY_T skid_q, skid_d;

    logic   w_accept;
    logic   w_retire;

    assign w_accept = in_valid && !skid_valid_q;
    assign w_retire = main_valid_q && out_ready;

    // Next-state for slot occupancy and contents.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        case ({main_valid_q, skid_valid_q})
            c_st_empty: begin
                if (w_accept) begin
                    main_valid_d = 1'b1;
                    main_d       = in_data;
                end
            end
            c_st_full1: begin
                if (w_retire && w_accept) begin
                    main_d = in_data;
                end else if (w_retire) begin
                    main_valid_d = 1'b0;
                end else if (w_accept) begin
                    skid_valid_d = 1'b1;
                    skid_d       = in_data;
                end
            end
            c_st_full2: begin
                // Skid entry moves up only when main retires, never overtaking.
                if (w_retire) begin
                    main_d       = skid_q;
                    skid_valid_d = 1'b0;
                end
            end
            default: begin
                // {0,1} is unreachable; recover to empty.
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase
    end

    // Slot registers with synchronous active-low reset that discards both entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule : wb_skid_buf
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wb_stage
//  Description : Execute-to-writeback stage after the 32-bit ALU. Buffers ALU
//                results through a skid buffer, presents register-file write
//                requests and keeps the architectural zero/sign flags, which
//                are updated when an entry with setf=1 retires.
//                Optional macro ALU_WB_BRANCH_EN enables br_taken evaluation
//                from the flags; otherwise br_taken is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_stage
    import alu_wb_pkg::*;
#(
    parameter int N  = N_DEFAULT,   // must match the ALU width
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_z,
    input  logic          in_zf,
    input  logic          in_sf,
    input  logic [RW-1:0] in_rd,
    input  logic          in_setf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_z,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic          flag_zf,
    output logic          flag_sf,
    input  logic [1:0]    br_cond,
    output logic          br_taken
);

    wb_entry_t w_in_entry;
    wb_entry_t w_out_entry;
    logic      w_retire;

    logic      flag_zf_q, flag_zf_d;
    logic      flag_sf_q, flag_sf_d;

    assign w_in_entry.z    = in_z;
    assign w_in_entry.zf   = in_zf;
    assign w_in_entry.sf   = in_sf;
    assign w_in_entry.rd   = in_rd;
    assign w_in_entry.setf = in_setf;

    wb_skid_buf #(
        .ENTRY_T (wb_entry_t)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_entry)
    );

    assign out_z    = w_out_entry.z;
    assign out_rd   = w_out_entry.rd;
    // Writes to x0 still flow through (and may set flags) but never write.
    assign out_we   = out_valid && (w_out_entry.rd != '0);
    assign w_retire = out_valid && out_ready;

    // Flags follow the retiring entry only when it requests a flag update.
    always_comb begin
        flag_zf_d = flag_zf_q;
        flag_sf_d = flag_sf_q;
        if (w_retire && w_out_entry.setf) begin
            flag_zf_d = w_out_entry.zf;
            flag_sf_d = w_out_entry.sf;
        end
    end

    // Architectural flag register; reset clears rather than applying in-flight entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_zf_q <= 1'b0;
            flag_sf_q <= 1'b0;
        end else begin
            flag_zf_q <= flag_zf_d;
            flag_sf_q <= flag_sf_d;
        end
    end

    assign flag_zf = flag_zf_q;
    assign flag_sf = flag_sf_q;

`ifdef ALU_WB_BRANCH_EN
    br_cond_t w_cond;
    assign w_cond = br_cond_t'(br_cond);

    // Branch resolution straight from the architectural flags.
    always_comb begin
        br_taken = 1'b0;
        case (w_cond)
            BR_AL:   br_taken = 1'b1;
            BR_EQ:   br_taken = flag_zf_q;
            BR_NE:   br_taken = !flag_zf_q;
            BR_LT:   br_taken = flag_sf_q;
            default: br_taken = 1'b0;
        endcase
    end
`else
    // Branch evaluation disabled: condition input is intentionally unused.
    logic w_unused_br_cond;
    assign w_unused_br_cond = ^br_cond;
    assign br_taken         = 1'b0;
`endif

endmodule : alu_wb_stage
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_wb_stage
//  Description : Directed self-checking bench for alu_wb_stage. Inputs are
//                driven and outputs sampled 1ns after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_z;
    logic        in_zf;
    logic        in_sf;
    logic [4:0]  in_rd;
    logic        in_setf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        flag_zf;
    logic        flag_sf;
    logic [1:0]  br_cond;
    logic        br_taken;

    int checks   = 0;
    int failures = 0;

    alu_wb_stage #(
        .N  (32),
        .RW (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .in_zf     (in_zf),
        .in_sf     (in_sf),
        .in_rd     (in_rd),
        .in_setf   (in_setf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .flag_zf   (flag_zf),
        .flag_sf   (flag_sf),
        .br_cond   (br_cond),
        .br_taken  (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] z, input logic zf,
                         input logic sf, input logic [4:0] rd, input logic setf);
        in_valid = v;
        in_z     = z;
        in_zf    = zf;
        in_sf    = sf;
        in_rd    = rd;
        in_setf  = setf;
    endtask

    // Expected br_taken for flags zf=1, sf=0, per condition code 0..3.
    logic [3:0] exp_br_zf1;

    initial begin
`ifdef ALU_WB_BRANCH_EN
        exp_br_zf1 = 4'b0011;   // bit i = result for br_cond i: AL=1 EQ=1 NE=0 LT=0
`else
        exp_br_zf1 = 4'b0000;
`endif
        rst_n     = 1'b0;
        out_ready = 1'b1;
        br_cond   = 2'd1;
        drive(1'b1, 32'h77, 1'b1, 1'b1, 5'd3, 1'b1);

        // Reset held for two edges with a valid input offered.
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_z",     out_z,              32'd0);
        chk("rst_out_rd",    {27'd0, out_rd},    32'd0);
        chk("rst_out_we",    {31'd0, out_we},    32'd0);
        chk("rst_flags",     {30'd0, flag_zf, flag_sf}, 32'd0);

        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("rst_no_capture", {31'd0, out_valid}, 32'd0);

        // Streaming at full rate, latency 1, flags one cycle after retirement.
        drive(1'b1, 32'h0, 1'b1, 1'b0, 5'd3, 1'b1);
        tick();
        chk("s0_valid", {31'd0, out_valid}, 32'd1);
        chk("s0_z",     out_z,              32'h0);
        chk("s0_rd_we", {26'd0, out_rd, out_we}, {26'd0, 5'd3, 1'b1});
        drive(1'b1, 32'h11223400, 1'b0, 1'b0, 5'd3, 1'b1);
        tick();
        chk("s1_z",  out_z,                  32'h11223400);
        chk("s1_zf", {31'd0, flag_zf},       32'd1);
        drive(1'b1, 32'h00000000, 1'b1, 1'b0, 5'd3, 1'b1);
        tick();
        chk("s2_z",  out_z,                  32'h0);
        chk("s2_zf", {31'd0, flag_zf},       32'd0);
        drive(1'b1, 32'hfffffffe, 1'b0, 1'b1, 5'd3, 1'b1);
        tick();
        chk("s3_z",  out_z,                  32'hfffffffe);
        chk("s3_zf", {31'd0, flag_zf},       32'd1);
        chk("s3_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("s4_drain", {31'd0, out_valid}, 32'd0);
        chk("s4_flags", {30'd0, flag_zf, flag_sf}, 32'd1);

        // Backpressure: two entries offered while out_ready is low.
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b1, 1'b0, 5'd4, 1'b0);
        tick();
        chk("bp1_z",     out_z,              32'hA);
        chk("bp1_ready", {31'd0, in_ready},  32'd1);
        drive(1'b1, 32'hB, 1'b1, 1'b0, 5'd4, 1'b0);
        tick();
        chk("bp2_z",     out_z,              32'hA);
        chk("bp2_ready", {31'd0, in_ready},  32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("bp3_z",     out_z,              32'hA);
        chk("bp3_valid", {31'd0, out_valid}, 32'd1);
        chk("bp3_ready", {31'd0, in_ready},  32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp4_z",     out_z,              32'hB);
        chk("bp4_ready", {31'd0, in_ready},  32'd1);
        tick();
        chk("bp5_drain", {31'd0, out_valid}, 32'd0);
        chk("bp5_flags", {30'd0, flag_zf, flag_sf}, 32'd1);

        // rd=0 entry flows through without a write but still sets flags.
        drive(1'b1, 32'h5, 1'b1, 1'b0, 5'd0, 1'b1);
        tick();
        chk("rd0_valid", {31'd0, out_valid}, 32'd1);
        chk("rd0_we",    {31'd0, out_we},    32'd0);
        chk("rd0_z",     out_z,              32'h5);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("rd0_flags", {30'd0, flag_zf, flag_sf}, 32'd2);

        // Branch evaluation with zf=1, sf=0.
        for (int c = 0; c < 4; c++) begin
            br_cond = c[1:0];
            #1;
            chk($sformatf("br_cond%0d", c), {31'd0, br_taken}, {31'd0, exp_br_zf1[c]});
        end

        // Clear zf, then a setf=0 entry with zf=1 must leave it clear.
        drive(1'b1, 32'h1, 1'b0, 1'b0, 5'd2, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("clr_zf", {31'd0, flag_zf}, 32'd0);
        drive(1'b1, 32'h0, 1'b1, 1'b1, 5'd2, 1'b0);
        tick();
        chk("nosetf_we", {31'd0, out_we}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("nosetf_flags", {30'd0, flag_zf, flag_sf}, 32'd0);

        // Reset mid-operation discards buffered entries.
        out_ready = 1'b0;
        drive(1'b1, 32'hC, 1'b1, 1'b1, 5'd1, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_ready", {31'd0, in_ready},  32'd1);
        tick();
        chk("mrst_empty", {31'd0, out_valid}, 32'd0);
        chk("mrst_flags", {30'd0, flag_zf, flag_sf}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_wb_stage
`default_nettype wire
